// File: rtl/rotl_serial.sv
// rotl_serial: left-rotate by amt, one bit per cycle through an IDLE/ROT/HOLD handshake FSM.
// Define ROTL_FAST_EN to rotate in a single step on accept and skip ROT entirely.
module rotl_serial #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ROT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

`ifdef ROTL_FAST_EN
    // Upper half of the doubled operand shifted left is the rotation.
    logic [2*WIDTH-1:0] dbl;
    assign dbl = {a, a} << amt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
`ifdef ROTL_FAST_EN
                y_d     = dbl[2*WIDTH-1:WIDTH];
                cnt_d   = '0;
                state_d = HOLD;
`else
                y_d     = a;
                cnt_d   = amt;
                state_d = (amt == '0) ? HOLD : ROT;
`endif
            end
            ROT: begin
                y_d     = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
                cnt_d   = cnt_q - AMT_W'(1);
                state_d = (cnt_q == AMT_W'(1)) ? HOLD : ROT;
            end
            HOLD: state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == ROT);
    assign y         = y_q;
endmodule
